aes_spi_master: RTL and testbench

Host-side SPI master that drives the serial port of the `aes` core. On a `start` request it shifts in the 256-bit {plaintext, key} frame with `load` held high, then drops `load` and waits for `done`. It then clocks out the 128-bit ciphertext and presents it on a parallel bus with a one-cycle `valid` strobe. It sits directly upstream and downstream of `aes`, sharing its `clk`, and lets on-chip logic or a bench use the core through a simple parallel request/response interface.

---
 rtl/aes_spi_master.sv | 205 ++++++++++++++++++++
 tb/tb_aes_spi_master.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_spi_master.sv
// -----------------------------------------------------------------------------
// aes_spi_master
//
// Host-side SPI master for the serial port of the aes core. A start request
// captures {plaintext, key}, shifts the 256-bit frame out MSB first with load
// held high, releases load, waits for done, then clocks the 128-bit result
// back in and presents it on a parallel bus with a one-cycle valid strobe.
// A done that never arrives ends the transaction with a one-cycle error pulse.
//
// Parameters
//   CLK_DIV    clk cycles per sck half-period (>= 1)
//   TIMEOUT    clk cycles to wait for done after load falls (>= 1)
//
// Ports
//   clk          in   system clock shared with aes, rising edge only
//   reset_n      in   synchronous active-low reset
//   start        in   transaction request, sampled only while idle
//   plaintext    in   128-bit block, captured on an accepted start
//   key          in   128-bit key, captured on an accepted start
//   sck          out  SPI clock to aes
//   sdi          out  serial data to aes, MSB first
//   sdo          in   serial data from aes
//   load         out  frame-load strobe to aes
//   done         in   ciphertext-ready flag from aes, synchronous to clk
//   busy         out  high from an accepted start until return to idle
//   valid        out  one-cycle pulse when cyphertext is updated
//   error        out  one-cycle pulse on a done timeout
//   cyphertext   out  last received result, held until the next valid
// -----------------------------------------------------------------------------
module aes_spi_master #(
   parameter int CLK_DIV = 2,
   parameter int TIMEOUT = 1024
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         start,
   input  logic [127:0] plaintext,
   input  logic [127:0] key,
   output logic         sck,
   output logic         sdi,
   input  logic         sdo,
   output logic         load,
   input  logic         done,
   output logic         busy,
   output logic         valid,
   output logic         error,
   output logic [127:0] cyphertext
);

   // One bit slot is 2*CLK_DIV cycles: sck low for the first half, high for
   // the second half.
   localparam int SLOT = 2 * CLK_DIV;
   localparam int PW   = $clog2(SLOT);
   localparam int TW   = $clog2(TIMEOUT + 1);

   localparam logic [PW-1:0] PH_LAST     = PW'(SLOT - 1);
   localparam logic [PW-1:0] PH_HIGH     = PW'(CLK_DIV);
   localparam logic [PW-1:0] PH_REL_LAST = PW'(CLK_DIV - 1);
   localparam logic [TW-1:0] WAIT_LAST   = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SHIFT_IN,
      S_RELEASE,
      S_WAIT_DONE,
      S_SHIFT_OUT,
      S_FINISH
   } state_t;

   state_t        state;
   logic [PW-1:0] phase;      // position inside the current bit slot / release
   logic [8:0]    bit_cnt;    // slot index within SHIFT_IN or SHIFT_OUT
   logic [TW-1:0] wait_cnt;   // cycles spent in WAIT_DONE

   // Bits still to be sent after the one currently on sdi. The MSB of the
   // frame goes straight to sdi on start, so only 255 bits need storing.
   logic [254:0]  frame;

   // Received bits so far; the final sample is appended on the way into
   // cyphertext, so 127 bits of history are enough.
   logic [126:0]  rx_shift;

   logic          slot_end;
   logic [PW-1:0] phase_inc;

   assign slot_end  = (phase == PH_LAST);
   assign phase_inc = phase + PW'(1);

   // NOTE: every register in this block is assigned with <= so that all of
   // them update together from pre-edge values; reading frame[254] into sdi
   // in the same edge that shifts frame depends on that.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= S_IDLE;
         phase      <= '0;
         bit_cnt    <= '0;
         wait_cnt   <= '0;
         sck        <= 1'b0;
         sdi        <= 1'b0;
         load       <= 1'b0;
         busy       <= 1'b0;
         valid      <= 1'b0;
         error      <= 1'b0;
         cyphertext <= '0;
         // NOTE: frame and rx_shift are pure datapath that is always loaded
         // before it is read, so they are deliberately left out of reset.
      end else begin
         // Strobes default low and are raised for exactly one cycle below.
         valid <= 1'b0;
         error <= 1'b0;

         case (state)
            S_IDLE: begin
               sck <= 1'b0;
               if (start) begin
                  frame   <= {plaintext[126:0], key};
                  sdi     <= plaintext[127];
                  load    <= 1'b1;
                  busy    <= 1'b1;
                  phase   <= '0;
                  bit_cnt <= '0;
                  state   <= S_SHIFT_IN;
               end
            end

            S_SHIFT_IN: begin
               if (slot_end) begin
                  // Slot boundary: sck falls and the next bit is presented
                  // in the same edge, so sdi only moves while sck is low.
                  phase <= '0;
                  sck   <= 1'b0;
                  if (bit_cnt == 9'd255) begin
                     state <= S_RELEASE;
                  end else begin
                     bit_cnt <= bit_cnt + 9'd1;
                     sdi     <= frame[254];
                     frame   <= {frame[253:0], 1'b0};
                  end
               end else begin
                  phase <= phase_inc;
                  sck   <= (phase_inc >= PH_HIGH);
               end
            end

            S_RELEASE: begin
               // load stays high with sck low for one half-period so the last
               // bit is settled in aes before the frame is committed.
               if (phase == PH_REL_LAST) begin
                  load     <= 1'b0;
                  sdi      <= 1'b0;
                  wait_cnt <= '0;
                  state    <= S_WAIT_DONE;
               end else begin
                  phase <= phase_inc;
               end
            end

            S_WAIT_DONE: begin
               if (done) begin
                  phase   <= '0;
                  bit_cnt <= '0;
                  state   <= S_SHIFT_OUT;
               end else if (wait_cnt == WAIT_LAST) begin
                  error <= 1'b1;
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end else begin
                  wait_cnt <= wait_cnt + TW'(1);
               end
            end

            S_SHIFT_OUT: begin
               if (slot_end) begin
                  // Sample on the last high phase, i.e. in the edge that
                  // drops sck; aes only moves sdo after that falling edge.
                  phase    <= '0;
                  sck      <= 1'b0;
                  rx_shift <= {rx_shift[125:0], sdo};
                  if (bit_cnt == 9'd127) begin
                     cyphertext <= {rx_shift, sdo};
                     valid      <= 1'b1;
                     busy       <= 1'b0;
                     state      <= S_FINISH;
                  end else begin
                     bit_cnt <= bit_cnt + 9'd1;
                  end
               end else begin
                  phase <= phase_inc;
                  sck   <= (phase_inc >= PH_HIGH);
               end
            end

            S_FINISH: begin
               // One dead cycle so a start held high is only taken once idle.
               state <= S_IDLE;
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_aes_spi_master.sv
// -----------------------------------------------------------------------------
// tb_aes_spi_master
//
// Self-checking bench for aes_spi_master. Three instances run with different
// CLK_DIV/TIMEOUT settings, each attached to a behavioural aes slave that
// captures the frame on sck rises while load is high, raises done a few
// cycles after load falls, and returns a chosen 128-bit response MSB first,
// moving sdo on each sck fall.
//   instance 0: CLK_DIV=2, TIMEOUT=16
//   instance 1: CLK_DIV=1, TIMEOUT=64
//   instance 2: CLK_DIV=3, TIMEOUT=64
// -----------------------------------------------------------------------------
module tb_aes_spi_master;

   localparam int N_DUT    = 3;
   localparam int DONE_DLY = 5;

   typedef struct packed {
      logic [255:0] rx;
      int rise1;
      int rise0;
      int sdi_hi;
      int load_rise_cnt;
      int valid_cnt;
      int err_cnt;
      int t_load_rise;
      int t_load_fall;
      int t_done;
      int t_valid;
      int t_err;
      int hi_min;
      int hi_max;
      int lo_min;
      int lo_max;
      int gap_min;
      int gap_max;
   } stats_t;

   typedef struct {
      int           d;
      logic [127:0] pt;
      logic [127:0] key;
      logic [127:0] resp;
      logic [127:0] exp_ct;
   } vec_t;

   logic             clk = 1'b0;
   logic             reset_n;
   logic [N_DUT-1:0] start;
   logic [127:0]     plaintext;
   logic [127:0]     key;
   logic [127:0]     resp;
   bit               done_en;
   bit               clr;
   int               cyc = 0;

   logic [N_DUT-1:0] sck_a, sdi_a, load_a, busy_a, valid_a, error_a;
   logic [127:0]     ct_a [N_DUT];
   stats_t           st_a [N_DUT];

   int n_checks = 0;
   int n_errors = 0;

   initial forever #5 clk = ~clk;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   function automatic int div_of(input int d);
      return (d == 0) ? 2 : (d == 1) ? 1 : 3;
   endfunction

   for (genvar g = 0; g < N_DUT; g++) begin : g_dut
      localparam int D = (g == 0) ? 2 : (g == 1) ? 1 : 3;
      localparam int T = (g == 0) ? 16 : 64;

      logic         sck, sdi, load, busy, valid, error;
      logic         sdo = 1'b0;
      logic         done = 1'b0;
      logic [127:0] ct;
      stats_t       st;

      aes_spi_master #(.CLK_DIV(D), .TIMEOUT(T)) u_dut (
         .clk        (clk),
         .reset_n    (reset_n),
         .start      (start[g]),
         .plaintext  (plaintext),
         .key        (key),
         .sck        (sck),
         .sdi        (sdi),
         .sdo        (sdo),
         .load       (load),
         .done       (done),
         .busy       (busy),
         .valid      (valid),
         .error      (error),
         .cyphertext (ct)
      );

      // Behavioural slave and monitor, evaluated on the falling clk edge.
      initial begin
         logic [127:0] sh;
         logic         sck_q, load_q;
         int           run, dcnt;
         bit           seen_valid;
         sh = '0; sck_q = 1'b0; load_q = 1'b0; run = 0; dcnt = -1;
         seen_valid = 1'b0; st = '0;
         forever begin
            @(negedge clk);
            if (clr) begin
               st = '0;
               st.hi_min = 9999; st.lo_min = 9999; st.gap_min = 9999;
               seen_valid = 1'b0;
               dcnt = -1;
            end
            if (done) done = 1'b0;

            if (sck && !sck_q) begin
               // Low run before a rise counts only between slots of one phase.
               if ((load && st.rise1 > 0) || (!load && st.rise0 > 0)) begin
                  if (run < st.lo_min) st.lo_min = run;
                  if (run > st.lo_max) st.lo_max = run;
               end
               if (load) begin
                  st.rise1++;
                  st.rx = {st.rx[254:0], sdi};
                  if (sdi) st.sdi_hi++;
               end else begin
                  st.rise0++;
               end
            end
            if (!sck && sck_q) begin
               if (run < st.hi_min) st.hi_min = run;
               if (run > st.hi_max) st.hi_max = run;
               if (!load) begin
                  sh  = {sh[126:0], 1'b0};
                  sdo = sh[127];
               end
            end
            run   = (sck != sck_q) ? 1 : run + 1;
            sck_q = sck;

            if (load && !load_q) begin
               st.load_rise_cnt++;
               st.t_load_rise = cyc;
               if (seen_valid) begin
                  if (cyc - st.t_valid < st.gap_min) st.gap_min = cyc - st.t_valid;
                  if (cyc - st.t_valid > st.gap_max) st.gap_max = cyc - st.t_valid;
               end
            end
            if (!load && load_q) begin
               st.t_load_fall = cyc;
               if (done_en) dcnt = DONE_DLY;
            end else if (dcnt > 0) begin
               dcnt--;
            end else if (dcnt == 0) begin
               done      = 1'b1;
               sh        = resp;
               sdo       = resp[127];
               st.t_done = cyc;
               dcnt      = -1;
            end
            load_q = load;

            if (valid) begin
               st.valid_cnt++;
               st.t_valid = cyc;
               seen_valid = 1'b1;
            end
            if (error) begin
               st.err_cnt++;
               st.t_err = cyc;
            end
         end
      end

      assign st_a[g]    = st;
      assign ct_a[g]    = ct;
      assign sck_a[g]   = sck;
      assign sdi_a[g]   = sdi;
      assign load_a[g]  = load;
      assign busy_a[g]  = busy;
      assign valid_a[g] = valid;
      assign error_a[g] = error;
   end

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic clear_stats();
      clr = 1'b1;
      @(negedge clk);
      #1 clr = 1'b0;
   endtask

   // Launch one transaction on instance d and wait (bounded) for valid/error.
   task automatic run_tx(input int d, input logic [127:0] pt, input logic [127:0] k,
                         input logic [127:0] rsp, input bit with_done, output bit ok);
      plaintext = pt;
      key       = k;
      resp      = rsp;
      done_en   = with_done;
      clear_stats();
      start[d] = 1'b1;
      @(negedge clk);
      start[d] = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 20000 && !ok; i++) begin
         @(negedge clk);
         #1;
         if (st_a[d].valid_cnt > 0 || st_a[d].err_cnt > 0) ok = 1'b1;
      end
      repeat (10) @(negedge clk);
      #1;
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t         vecs [4];
      bit           ok;
      int           d, dv;
      logic [127:0] prev_ct;

      vecs[0] = '{0, 128'h00112233445566778899AABBCCDDEEFF, 128'h000102030405060708090A0B0C0D0E0F,
                  128'h69C4E0D86A7B0430D8CDB78070B4C55A, 128'h69C4E0D86A7B0430D8CDB78070B4C55A};
      vecs[1] = '{0, {1'b1, 127'b0}, {127'b0, 1'b1},
                  {1'b1, 126'b0, 1'b1}, {1'b1, 126'b0, 1'b1}};
      vecs[2] = '{2, 128'h00112233445566778899AABBCCDDEEFF, 128'h000102030405060708090A0B0C0D0E0F,
                  128'h69C4E0D86A7B0430D8CDB78070B4C55A, 128'h69C4E0D86A7B0430D8CDB78070B4C55A};
      vecs[3] = '{1, 128'hDEADBEEF0123456789ABCDEFCAFEF00D, 128'hFEDCBA9876543210F0E1D2C3B4A59687,
                  128'hA5A55A5A3C3CC3C30F0FF0F012345678, 128'hA5A55A5A3C3CC3C30F0FF0F012345678};

      reset_n = 1'b0; start = '0; plaintext = '0; key = '0; resp = '0;
      done_en = 1'b0; clr = 1'b1;
      repeat (3) @(negedge clk);
      clr = 1'b0;
      #1;

      // Reset values on every instance.
      for (int i = 0; i < N_DUT; i++) begin
         check($sformatf("rst%0d_sck", i),   sck_a[i],   0);
         check($sformatf("rst%0d_sdi", i),   sdi_a[i],   0);
         check($sformatf("rst%0d_load", i),  load_a[i],  0);
         check($sformatf("rst%0d_busy", i),  busy_a[i],  0);
         check($sformatf("rst%0d_valid", i), valid_a[i], 0);
         check($sformatf("rst%0d_error", i), error_a[i], 0);
         check($sformatf("rst%0d_ct", i),    ct_a[i],    0);
      end
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      // Table-driven full transactions.
      for (int i = 0; i < 4; i++) begin
         d  = vecs[i].d;
         dv = div_of(d);
         run_tx(d, vecs[i].pt, vecs[i].key, vecs[i].resp, 1'b1, ok);
         check($sformatf("v%0d_complete", i),  ok, 1);
         check($sformatf("v%0d_frame", i),     st_a[d].rx, {vecs[i].pt, vecs[i].key});
         check($sformatf("v%0d_sdi_ones", i),  st_a[d].sdi_hi, $countones({vecs[i].pt, vecs[i].key}));
         check($sformatf("v%0d_ct", i),        ct_a[d], vecs[i].exp_ct);
         check($sformatf("v%0d_sck_load1", i), st_a[d].rise1, 256);
         check($sformatf("v%0d_sck_load0", i), st_a[d].rise0, 128);
         check($sformatf("v%0d_load_len", i),  st_a[d].t_load_fall - st_a[d].t_load_rise, 513 * dv);
         check($sformatf("v%0d_valid_lat", i), st_a[d].t_valid - st_a[d].t_done, 1 + 256 * dv);
         check($sformatf("v%0d_valid_cnt", i), st_a[d].valid_cnt, 1);
         check($sformatf("v%0d_err_cnt", i),   st_a[d].err_cnt, 0);
         check($sformatf("v%0d_busy", i),      busy_a[d], 0);
         check($sformatf("v%0d_hi_min", i),    st_a[d].hi_min, dv);
         check($sformatf("v%0d_hi_max", i),    st_a[d].hi_max, dv);
         check($sformatf("v%0d_lo_min", i),    st_a[d].lo_min, dv);
         check($sformatf("v%0d_lo_max", i),    st_a[d].lo_max, dv);
      end

      // Done never arrives on instance 0 (TIMEOUT=16).
      prev_ct = vecs[1].exp_ct;
      run_tx(0, 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0, 128'h1, 128'hFFFF, 1'b0, ok);
      check("to_complete",  ok, 1);
      check("to_err_lat",   st_a[0].t_err - st_a[0].t_load_fall, 16);
      check("to_err_cnt",   st_a[0].err_cnt, 1);
      check("to_valid_cnt", st_a[0].valid_cnt, 0);
      check("to_busy",      busy_a[0], 0);
      check("to_ct_held",   ct_a[0], prev_ct);
      check("to_sck_load1", st_a[0].rise1, 256);
      check("to_sck_load0", st_a[0].rise0, 0);

      // start held high for 3000 cycles on instance 1 (CLK_DIV=1). One
      // transaction takes 778 cycles start-to-start (513 + 7 + 256 + 2), so
      // accepted starts fall at +1, +779, +1557 and +2335: four in total.
      plaintext = vecs[3].pt; key = vecs[3].key; resp = vecs[3].resp; done_en = 1'b1;
      clear_stats();
      start[1] = 1'b1;
      repeat (3000) @(negedge clk);
      start[1] = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 2000 && !ok; i++) begin
         @(negedge clk);
         #1;
         if (!busy_a[1]) ok = 1'b1;
      end
      repeat (5) @(negedge clk);
      #1;
      check("held_idle",      ok, 1);
      check("held_tx_cnt",    st_a[1].load_rise_cnt, 4);
      check("held_valid_cnt", st_a[1].valid_cnt, st_a[1].load_rise_cnt);
      check("held_sck_load1", st_a[1].rise1, 256 * st_a[1].load_rise_cnt);
      check("held_sck_load0", st_a[1].rise0, 128 * st_a[1].valid_cnt);
      check("held_gap_min",   st_a[1].gap_min, 2);
      check("held_gap_max",   st_a[1].gap_max, 2);
      check("held_ct",        ct_a[1], vecs[3].exp_ct);

      // Reset in the middle of SHIFT_IN on instance 0, after 100 bits.
      plaintext = vecs[0].pt; key = vecs[0].key; resp = vecs[0].resp; done_en = 1'b1;
      clear_stats();
      start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 2000 && !ok; i++) begin
         @(negedge clk);
         #1;
         if (st_a[0].rise1 == 100) ok = 1'b1;
      end
      check("mid_reached", ok, 1);
      reset_n = 1'b0;
      @(negedge clk);
      #1;
      check("mid_load",  load_a[0],  0);
      check("mid_sck",   sck_a[0],   0);
      check("mid_busy",  busy_a[0],  0);
      check("mid_valid", valid_a[0], 0);
      check("mid_ct",    ct_a[0],    0);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      run_tx(0, vecs[0].pt, vecs[0].key, vecs[0].resp, 1'b1, ok);
      check("post_complete",  ok, 1);
      check("post_frame",     st_a[0].rx, {vecs[0].pt, vecs[0].key});
      check("post_ct",        ct_a[0], vecs[0].exp_ct);
      check("post_sck_load1", st_a[0].rise1, 256);
      check("post_sck_load0", st_a[0].rise0, 128);
      check("post_valid_cnt", st_a[0].valid_cnt, 1);
      check("post_busy",      busy_a[0], 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
